sccb_target: RTL and testbench

- SCCB responder (camera-side target) for the same 3-wire SCCB bus our SCCB master drives.
- Used as the on-FPGA camera model in the SCCB bench, and as a loopback target for bring-up.
- Oversamples SIOC/SIOD on the system clock and decodes START/STOP.
- Supports 3-phase write, 2-phase write (sets the register pointer) and 2-phase read, backed by an internal 256x8 register file.
- Exposes a host-side read port and a write-strobe side channel.

---
 rtl/sccb_target.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sccb_target.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder (camera-side target) on a 3-wire SCCB bus.
// SIOC/SIOD are oversampled on clk. START/STOP are decoded from the
// synchronised lines. The block supports 3-phase write, 2-phase write
// (which sets the pointer) and 2-phase read, backed by a 256x8 register file.
//
// Ports:
//   clk        system clock, at least 8x the SIOC frequency
//   reset      asynchronous, active-high reset
//   sioc       SCCB clock from the master
//   siod_i     SCCB data sampled from the pad
//   siod_o     SCCB data driven by the target
//   siod_oe    pad drive enable (1 = target drives siod_o)
//   host_addr  host-side register file read address
//   host_rdata combinational read of regfile[host_addr]
//   wr_strobe  one-clk pulse when a 3-phase write commits
//   wr_addr    register address of the last commit (held)
//   wr_data    data of the last commit (held)
//   busy       high from START to STOP
//   id_miss    one-clk pulse when the ID byte does not match DEV_ADDR
module sccb_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_o,
  output logic       siod_oe,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       id_miss
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_ID_ACK_R,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_NA,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sioc_sync_r;
  logic [SYNC_STAGES-1:0] siod_sync_r;
  logic                   sioc_prev_r;
  logic                   siod_prev_r;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic [7:0] ptr_r;
  logic [7:0] rdata_r;
  logic [7:0] regfile_r [0:255];

  logic       sioc_s;
  logic       siod_s;
  logic       rise_s;
  logic       fall_s;
  logic       start_s;
  logic       stop_s;
  logic       last_bit_s;
  logic [7:0] byte_s;

  // Synchronise both bus lines and keep one cycle of history for edge detection.
  // The idle bus is high, so the flops reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sioc_sync_r <= {SYNC_STAGES{1'b1}};
      siod_sync_r <= {SYNC_STAGES{1'b1}};
      sioc_prev_r <= 1'b1;
      siod_prev_r <= 1'b1;
    end else begin
      sioc_sync_r <= {sioc_sync_r[SYNC_STAGES-2:0], sioc};
      siod_sync_r <= {siod_sync_r[SYNC_STAGES-2:0], siod_i};
      sioc_prev_r <= sioc_sync_r[SYNC_STAGES-1];
      siod_prev_r <= siod_sync_r[SYNC_STAGES-1];
    end
  end

  assign sioc_s     = sioc_sync_r[SYNC_STAGES-1];
  assign siod_s     = siod_sync_r[SYNC_STAGES-1];
  assign rise_s     = sioc_s & ~sioc_prev_r;
  assign fall_s     = ~sioc_s & sioc_prev_r;
  // START/STOP need sioc high on both sides of the siod edge.
  assign start_s    = sioc_s & sioc_prev_r & siod_prev_r & ~siod_s;
  assign stop_s     = sioc_s & sioc_prev_r & ~siod_prev_r & siod_s;
  assign byte_s     = {shift_r, siod_s};
  assign last_bit_s = (bit_cnt_r == 4'd0);
  assign host_rdata = regfile_r[host_addr];

  // Protocol FSM, register file and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd7;
      shift_r   <= 7'd0;
      ptr_r     <= 8'd0;
      rdata_r   <= 8'd0;
      siod_o    <= 1'b1;
      siod_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
      id_miss   <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        regfile_r[i] <= 8'h00;
      end
    end else begin
      wr_strobe <= 1'b0;
      id_miss   <= 1'b0;
      if (stop_s) begin
        state_r <= ST_IDLE;
        siod_oe <= 1'b0;
        siod_o  <= 1'b1;
        busy    <= 1'b0;
      end else if (start_s) begin
        // Repeated START lands here too; the pointer is deliberately kept.
        state_r   <= ST_ID;
        bit_cnt_r <= 4'd7;
        siod_oe   <= 1'b0;
        siod_o    <= 1'b1;
        busy      <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            siod_oe <= 1'b0;
          end

          ST_ID: begin
            if (rise_s) begin
              shift_r <= byte_s[6:0];
              if (last_bit_s) begin
                if (byte_s[7:1] == DEV_ADDR) begin
                  state_r <= byte_s[0] ? ST_ID_ACK_R : ST_ID_ACK;
                end else begin
                  id_miss <= 1'b1;
                  state_r <= ST_IGNORE;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r - 4'd1;
              end
            end
          end

          // In the ACK states siod_oe doubles as the phase flag: the first
          // falling edge (8th) starts the drive, the next one (9th) ends it.
          ST_ID_ACK: begin
            if (fall_s) begin
              if (!siod_oe) begin
                siod_oe <= 1'b1;
                siod_o  <= 1'b0;
              end else begin
                siod_oe   <= 1'b0;
                siod_o    <= 1'b1;
                bit_cnt_r <= 4'd7;
                state_r   <= ST_SUB;
              end
            end
          end

          // On the 9th falling edge the drive continues straight into the MSB of read data.
          ST_ID_ACK_R: begin
            if (fall_s) begin
              if (!siod_oe) begin
                siod_oe <= 1'b1;
                siod_o  <= 1'b0;
              end else begin
                rdata_r   <= regfile_r[ptr_r];
                siod_o    <= regfile_r[ptr_r][7];
                bit_cnt_r <= 4'd7;
                state_r   <= ST_RDATA;
              end
            end
          end

          ST_SUB: begin
            if (rise_s) begin
              shift_r <= byte_s[6:0];
              if (last_bit_s) begin
                ptr_r   <= byte_s;
                state_r <= ST_SUB_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r - 4'd1;
              end
            end
          end

          ST_SUB_ACK: begin
            if (fall_s) begin
              if (!siod_oe) begin
                siod_oe <= 1'b1;
                siod_o  <= 1'b0;
              end else begin
                siod_oe   <= 1'b0;
                siod_o    <= 1'b1;
                bit_cnt_r <= 4'd7;
                state_r   <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (rise_s) begin
              shift_r <= byte_s[6:0];
              if (last_bit_s) begin
                regfile_r[ptr_r] <= byte_s;
                wr_strobe        <= 1'b1;
                wr_addr          <= ptr_r;
                wr_data          <= byte_s;
                state_r          <= ST_WDATA_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r - 4'd1;
              end
            end
          end

          ST_WDATA_ACK: begin
            if (fall_s) begin
              if (!siod_oe) begin
                siod_oe <= 1'b1;
                siod_o  <= 1'b0;
              end else begin
                siod_oe <= 1'b0;
                siod_o  <= 1'b1;
                state_r <= ST_IGNORE;
              end
            end
          end

          // The counter counts master samples. It wraps from 0 to 15 after the
          // 8th rising edge, and the following falling edge releases the line.
          ST_RDATA: begin
            if (rise_s) begin
              bit_cnt_r <= bit_cnt_r - 4'd1;
            end else if (fall_s) begin
              if (bit_cnt_r == 4'd15) begin
                siod_oe <= 1'b0;
                siod_o  <= 1'b1;
                state_r <= ST_RDATA_NA;
              end else begin
                siod_o <= rdata_r[bit_cnt_r[2:0]];
              end
            end
          end

          ST_RDATA_NA: begin
            siod_oe <= 1'b0;
            if (fall_s) begin
              state_r <= ST_IGNORE;
            end
          end

          ST_IGNORE: begin
            siod_oe <= 1'b0;
          end

          default: begin
            state_r <= ST_IDLE;
            siod_oe <= 1'b0;
            siod_o  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target. A bit-banged SCCB master
// drives the bus, and the expected values are hand-computed.
module tb_sccb_target;

  localparam int Q = 6;  // clk cycles per quarter SIOC bit phase

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sioc_m = 1'b1;
  logic       siod_m = 1'b1;
  logic       siod_i;
  logic       siod_o;
  logic       siod_oe;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       id_miss;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_miss   = 0;
  int oe_leak  = 0;
  logic oe_window = 1'b0;
  logic [7:0] last_addr = 8'd0;
  logic [7:0] last_data = 8'd0;

  // Open-drain pad: the line is low if either side pulls it low.
  assign siod_i = siod_m & (siod_oe ? siod_o : 1'b1);

  sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sioc(sioc_m), .siod_i(siod_i),
    .siod_o(siod_o), .siod_oe(siod_oe), .host_addr(host_addr),
    .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .id_miss(id_miss)
  );

  always #5 clk = ~clk;

  // Bus monitors: strobe/miss pulse counts and target drive outside the allowed windows.
  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strobe  <= n_strobe + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (id_miss) n_miss <= n_miss + 1;
    if (siod_oe && !oe_window) oe_leak <= oe_leak + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s, output logic oe);
    siod_m = b;
    wait_q();
    sioc_m = 1'b1;
    wait_q();
    s  = siod_i;
    oe = siod_oe;
    wait_q();
    sioc_m = 1'b0;
    wait_q();
  endtask

  task automatic start_cond();
    siod_m = 1'b1;
    wait_q();
    sioc_m = 1'b1;
    wait_q();
    siod_m = 1'b0;
    wait_q();
    sioc_m = 1'b0;
    wait_q();
  endtask

  task automatic stop_cond();
    siod_m = 1'b0;
    wait_q();
    sioc_m = 1'b1;
    wait_q();
    siod_m = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_ack, input logic keep_win,
                           output logic ack, output logic oe_ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && expect_ack) oe_window = 1'b1;
      clk_bit(b[i], s, o);
    end
    clk_bit(1'b1, ack, oe_ack);
    if (!keep_win) oe_window = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic s, o;
    for (int i = 7; i > 7 - n; i--) clk_bit(b[i], s, o);
  endtask

  task automatic read_byte(output logic [7:0] d, output logic oe_na);
    logic s, o;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s, o);
      d = {d[6:0], s};
    end
    oe_window = 1'b0;
    clk_bit(1'b1, s, oe_na);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_addr = a;
    #1;
    d = host_rdata;
  endtask

  task automatic write3(input logic [7:0] sub, input logic [7:0] dat, input string tag);
    logic a, o;
    start_cond();
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    check_eq({tag, "_id_ack"}, {31'd0, a}, 32'd0);
    send_byte(sub, 1'b1, 1'b0, a, o);
    check_eq({tag, "_sub_ack"}, {31'd0, a}, 32'd0);
    send_byte(dat, 1'b1, 1'b0, a, o);
    check_eq({tag, "_data_ack"}, {31'd0, a}, 32'd0);
    check_eq({tag, "_data_ack_oe"}, {31'd0, o}, 32'd1);
    stop_cond();
  endtask

  task automatic read2(output logic [7:0] d, output logic oe_na);
    logic a, o;
    start_cond();
    send_byte(8'h43, 1'b1, 1'b1, a, o);
    check_eq("rd_id_ack", {31'd0, a}, 32'd0);
    read_byte(d, oe_na);
    stop_cond();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic a, o, na;
    logic [7:0] d;
    int strobes0, nonzero;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_siod_o", {31'd0, siod_o}, 32'd1);
    check_eq("rst_siod_oe", {31'd0, siod_oe}, 32'd0);
    check_eq("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check_eq("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_id_miss", {31'd0, id_miss}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: 3-phase write of 0x80 to register 0x12
    start_cond();
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    check_eq("t1_id_ack", {31'd0, a}, 32'd0);
    check_eq("t1_id_ack_oe", {31'd0, o}, 32'd1);
    send_byte(8'h12, 1'b1, 1'b0, a, o);
    check_eq("t1_sub_ack", {31'd0, a}, 32'd0);
    send_byte(8'h80, 1'b1, 1'b0, a, o);
    check_eq("t1_data_ack", {31'd0, a}, 32'd0);
    stop_cond();
    check_eq("t1_strobes", n_strobe, 32'd1);
    check_eq("t1_wr_addr", {24'd0, last_addr}, 32'h12);
    check_eq("t1_wr_data", {24'd0, last_data}, 32'h80);
    check_eq("t1_wr_addr_held", {24'd0, wr_addr}, 32'h12);
    host_read(8'h12, d);
    check_eq("t1_host_rdata", {24'd0, d}, 32'h80);
    check_eq("t1_oe_leak", oe_leak, 32'd0);
    check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: write 0x0A to 0x55, 2-phase write sub 0x55, then 2-phase read
    write3(8'h55, 8'h0A, "t2w");
    check_eq("t2_strobes", n_strobe, 32'd2);
    start_cond();
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    send_byte(8'h55, 1'b1, 1'b0, a, o);
    check_eq("t2_2ph_sub_ack", {31'd0, a}, 32'd0);
    stop_cond();
    read2(d, na);
    check_eq("t2_read_data", {24'd0, d}, 32'h0A);
    check_eq("t2_na_oe", {31'd0, na}, 32'd0);
    check_eq("t2_no_strobe", n_strobe, 32'd2);
    check_eq("t2_oe_leak", oe_leak, 32'd0);

    // 3: wrong ID 0x60
    start_cond();
    send_byte(8'h60, 1'b0, 1'b0, a, o);
    check_eq("t3_id_nack", {31'd0, a}, 32'd1);
    send_byte(8'h12, 1'b0, 1'b0, a, o);
    check_eq("t3_sub_nack", {31'd0, a}, 32'd1);
    send_byte(8'h33, 1'b0, 1'b0, a, o);
    stop_cond();
    check_eq("t3_id_miss", n_miss, 32'd1);
    check_eq("t3_oe_leak", oe_leak, 32'd0);
    check_eq("t3_no_strobe", n_strobe, 32'd2);
    host_read(8'h12, d);
    check_eq("t3_reg12", {24'd0, d}, 32'h80);

    // 4: STOP after 4 data bits
    start_cond();
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    send_byte(8'h12, 1'b1, 1'b0, a, o);
    send_bits(8'hD5, 4);
    stop_cond();
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_oe", {31'd0, siod_oe}, 32'd0);
    check_eq("t4_no_strobe", n_strobe, 32'd2);
    host_read(8'h12, d);
    check_eq("t4_reg12", {24'd0, d}, 32'h80);
    read2(d, na);
    check_eq("t4_read_ptr12", {24'd0, d}, 32'h80);

    // 5: pointer to 0x55, repeated START mid-SUB, then read
    start_cond();
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    send_byte(8'h55, 1'b1, 1'b0, a, o);
    stop_cond();
    start_cond();
    send_byte(8'h42, 1'b1, 1'b0, a, o);
    send_bits(8'hAA, 4);
    start_cond();
    send_byte(8'h43, 1'b1, 1'b1, a, o);
    check_eq("t5_rd_id_ack", {31'd0, a}, 32'd0);
    read_byte(d, na);
    stop_cond();
    check_eq("t5_read_old_ptr", {24'd0, d}, 32'h0A);
    check_eq("t5_no_strobe", n_strobe, 32'd2);
    check_eq("t5_oe_leak", oe_leak, 32'd0);

    // 6: reset during read data bit 3 (register 0x55 = 0x0A, upper bits are 0)
    start_cond();
    send_byte(8'h43, 1'b1, 1'b1, a, o);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, a, o);
    check_eq("t6_pre_oe", {31'd0, siod_oe}, 32'd1);
    check_eq("t6_pre_o", {31'd0, siod_o}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_oe", {31'd0, siod_oe}, 32'd0);
    check_eq("t6_rst_o", {31'd0, siod_o}, 32'd1);
    oe_window = 1'b0;
    siod_m = 1'b1;
    repeat (2) @(negedge clk);
    sioc_m = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    nonzero = 0;
    for (int i = 0; i < 256; i++) begin
      host_read(i[7:0], d);
      if (d != 8'h00) nonzero++;
    end
    check_eq("t6_regfile_clear", nonzero, 32'd0);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_oe_leak", oe_leak, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
